// File: rtl/updi_pkg.sv
// Frame layout and receive FSM states shared by the UPDI line engines.
// Frames are stored raw: bit 0 is the start bit, then data LSB first, parity, two stops.
package updi_pkg;

    localparam int FRAME_W  = 12;
    localparam int START_B  = 0;
    localparam int DATA_LSB = 1;
    localparam int DATA_MSB = 8;
    localparam int PAR_B    = 9;
    localparam int STOP0_B  = 10;
    localparam int STOP1_B  = 11;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        START,
        DATA,
        STORE,
        DONE,
        WAIT
    } rx_state_t;

    // Even parity: data bits plus the parity bit must XOR to zero.
    function automatic logic frame_parity_bad(input logic [FRAME_W-1:0] f);
        return ^f[PAR_B:DATA_LSB];
    endfunction

    function automatic logic frame_stop_bad(input logic [FRAME_W-1:0] f);
        return !(f[STOP0_B] && f[STOP1_B]);
    endfunction

endpackage

// File: rtl/updi_bit_timer.sv
// Bit-period down-counter: restart loads a half or full period, strike fires on zero
// and the counter reloads a full period so later strikes land at mid-bit.
module updi_bit_timer #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic half_i,
    output logic strike_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (restart_i) begin
            cnt_d = half_i ? HALF_LOAD : FULL_LOAD;
        end else if (cnt_q == '0) begin
            cnt_d = FULL_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= FULL_LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign strike_o = (cnt_q == '0);

endmodule

// File: rtl/updi_line_rx.sv
// UPDI line receiver: deserialises 12-bit frames from the single-wire line and
// writes each raw frame into the shared SRAM, one word per frame.
module updi_line_rx
    import updi_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_W       = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ren,
    input  logic              rxd,
    input  logic [ADDR_W-1:0] n_frames,
    output logic              csb0,
    output logic              web0,
    output logic [ADDR_W-1:0] addr0,
    output logic [FRAME_W-1:0] din0,
    output logic              rend,
    output logic              busy,
    output logic              perr,
    output logic              ferr
);

    rx_state_t state_q, state_d;

    logic [1:0]         sync_q;
    logic               rxs;
    logic               rxs_prev_q;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  count_q, count_d;
    logic [ADDR_W-1:0]  count_inc;
    logic [ADDR_W-1:0]  nf_q, nf_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               restart;
    logic               half_sel;
    logic               strike;

    assign rxs       = sync_q[1];
    assign count_inc = count_q + 1'b1;

    updi_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .restart_i(restart),
        .half_i   (half_sel),
        .strike_o (strike)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        addr_d    = addr_q;
        count_d   = count_q;
        nf_d      = nf_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        restart   = 1'b0;
        half_sel  = 1'b1;

        case (state_q)
            IDLE: begin
                if (ren) begin
                    nf_d    = n_frames;
                    addr_d  = '0;
                    count_d = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = (n_frames == '0) ? DONE : HUNT;
                end
            end
            HUNT: begin
                if (!ren) begin
                    state_d = IDLE;
                end else if (rxs_prev_q && !rxs) begin
                    restart = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                if (!ren) begin
                    state_d = IDLE;
                end else if (strike) begin
                    if (rxs) begin
                        state_d = HUNT;
                    end else begin
                        shift_d   = {rxs, shift_q[FRAME_W-1:1]};
                        bit_cnt_d = 4'd1;
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (!ren) begin
                    state_d = IDLE;
                end else if (strike) begin
                    // Shifting right leaves the start bit in bit 0 after 12 samples.
                    shift_d = {rxs, shift_q[FRAME_W-1:1]};
                    if (bit_cnt_q == 4'(STOP1_B)) begin
                        state_d = STORE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            STORE: begin
                perr_d  = perr_q | frame_parity_bad(shift_q);
                ferr_d  = ferr_q | frame_stop_bad(shift_q);
                addr_d  = addr_q + 1'b1;
                count_d = count_inc;
                if (!ren) begin
                    state_d = IDLE;
                end else if (count_inc == nf_q) begin
                    state_d = DONE;
                end else begin
                    state_d = HUNT;
                end
            end
            DONE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (!ren) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            addr_q     <= '0;
            count_q    <= '0;
            nf_q       <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= {sync_q[0], rxd};
            rxs_prev_q <= rxs;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            nf_q       <= nf_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    assign csb0  = (state_q != STORE);
    assign web0  = (state_q != STORE);
    assign addr0 = addr_q;
    assign din0  = shift_q;
    assign rend  = (state_q == DONE);
    assign busy  = (state_q == HUNT) || (state_q == START) ||
                   (state_q == DATA) || (state_q == STORE);
    assign perr  = perr_q;
    assign ferr  = ferr_q;

endmodule

// File: tb/tb_updi_line_rx.sv
// Bench for updi_line_rx: drives serial frames on rxd and compares SRAM writes,
// rend timing and error flags against a frame-level model.
module tb_updi_line_rx;

    localparam int C  = 4;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          ren;
    logic          rxd;
    logic [AW-1:0] n_frames;
    logic          csb0;
    logic          web0;
    logic [AW-1:0] addr0;
    logic [11:0]   din0;
    logic          rend;
    logic          busy;
    logic          perr;
    logic          ferr;

    int total = 0;
    int bad   = 0;

    updi_line_rx #(
        .CLKS_PER_BIT(C),
        .ADDR_W      (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ren     (ren),
        .rxd     (rxd),
        .n_frames(n_frames),
        .csb0    (csb0),
        .web0    (web0),
        .addr0   (addr0),
        .din0    (din0),
        .rend    (rend),
        .busy    (busy),
        .perr    (perr),
        .ferr    (ferr)
    );

    always #5 clk = ~clk;

    // Observed SRAM traffic and end pulses.
    int          cyc = 0;
    int          wr_addr_q[$];
    logic [11:0] wr_din_q[$];
    int          last_wr_cyc = 0;
    int          rend_cnt = 0;
    int          rend_cyc = 0;
    bit          rd_seen = 0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (!csb0 && !web0) begin
                wr_addr_q.push_back(int'(addr0));
                wr_din_q.push_back(din0);
                last_wr_cyc = cyc;
            end
            if (!csb0 && web0) rd_seen = 1;
            if (rend) begin
                rend_cnt++;
                rend_cyc = cyc;
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stimulus for one job: frames, idle bits before each, optional glitch/low tail.
    logic [11:0] fr_q[$];
    int          gap_q[$];
    int          tail_low = 0;
    bit          glitch = 0;

    function automatic logic [11:0] mk(input logic [7:0] d, input logic p,
                                       input logic s0, input logic s1);
        return {s1, s0, p, d, 1'b0};
    endfunction

    task automatic idle_bits(input int n);
        rxd = 1'b1;
        repeat (n * C) @(negedge clk);
    endtask

    task automatic send_frame(input logic [11:0] raw);
        for (int b = 0; b < 12; b++) begin
            rxd = raw[b];
            repeat (C) @(negedge clk);
        end
    endtask

    task automatic build_rand(input int n, input bit allow_err);
        logic [7:0] d;
        logic       p, s0, s1, prev_s1;
        int         g, r;
        fr_q.delete();
        gap_q.delete();
        prev_s1 = 1'b1;
        for (int i = 0; i < n; i++) begin
            d  = 8'($urandom);
            p  = ^d;
            s0 = 1'b1;
            s1 = 1'b1;
            if (allow_err) begin
                r = $urandom_range(0, 7);
                if (r == 0) p = ~p;
                if (r == 1) s0 = 1'b0;
                if (r == 2) s1 = 1'b0;
            end
            g = (i == 0) ? 0 : $urandom_range(0, 2);
            // A low second stop bit leaves no falling edge unless the line idles.
            if (!prev_s1 && g == 0) g = 1;
            fr_q.push_back(mk(d, p, s0, s1));
            gap_q.push_back(g);
            prev_s1 = s1;
        end
    endtask

    task automatic run_job(input string tag);
        int   n, w, nchk, ones;
        logic ep, ef;
        logic [11:0] f;
        n = fr_q.size();
        wr_addr_q.delete();
        wr_din_q.delete();
        rend_cnt = 0;
        rd_seen  = 0;
        n_frames = AW'(n);
        @(negedge clk);
        ren = 1'b1;
        idle_bits(1);
        if (glitch) begin
            rxd = 1'b0;
            @(negedge clk);
            rxd = 1'b1;
            idle_bits(2);
        end
        foreach (fr_q[i]) begin
            idle_bits(gap_q[i]);
            send_frame(fr_q[i]);
        end
        if (tail_low > 0) begin
            rxd = 1'b0;
            repeat (tail_low * C) @(negedge clk);
            rxd = 1'b1;
        end
        w = 0;
        while (rend_cnt == 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        repeat (4) @(negedge clk);

        ep = 1'b0;
        ef = 1'b0;
        foreach (fr_q[i]) begin
            f    = fr_q[i];
            ones = $countones(f[8:1]) + int'(f[9]);
            if (ones % 2 != 0) ep = 1'b1;
            if (f[10] == 1'b0 || f[11] == 1'b0) ef = 1'b1;
        end

        $display("job %s: frames=%0d writes=%0d rend=%0d perr=%0b ferr=%0b",
                 tag, n, wr_din_q.size(), rend_cnt, perr, ferr);
        chk({tag, "_nwr"}, wr_din_q.size(), n);
        nchk = (wr_din_q.size() < n) ? wr_din_q.size() : n;
        for (int i = 0; i < nchk; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), wr_addr_q[i], i % (1 << AW));
            chk($sformatf("%s_din%0d", tag, i), wr_din_q[i], fr_q[i]);
        end
        chk({tag, "_rend_cnt"}, rend_cnt, 1);
        chk({tag, "_rend_lat"}, rend_cyc - last_wr_cyc, 1);
        chk({tag, "_perr"}, perr, ep);
        chk({tag, "_ferr"}, ferr, ef);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_noread"}, rd_seen, 0);
        ren = 1'b0;
        repeat (3) @(negedge clk);
        glitch   = 0;
        tail_low = 0;
    endtask

    initial begin
        logic [11:0] raw;
        rst      = 1'b1;
        ren      = 1'b0;
        rxd      = 1'b1;
        n_frames = '0;
        repeat (3) @(negedge clk);
        chk("rst_csb0", csb0, 1);
        chk("rst_web0", web0, 1);
        chk("rst_addr0", addr0, 0);
        chk("rst_din0", din0, 0);
        chk("rst_rend", rend, 0);
        chk("rst_busy", busy, 0);
        chk("rst_perr", perr, 0);
        chk("rst_ferr", ferr, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Two back-to-back frames.
        fr_q  = '{mk(8'h55, 1'b0, 1'b1, 1'b1), mk(8'hA3, 1'b0, 1'b1, 1'b1)};
        gap_q = '{0, 0};
        run_job("b2b");
        if (wr_din_q.size() >= 2) begin
            chk("b2b_raw0", wr_din_q[0], 12'hCAA);
            chk("b2b_raw1", wr_din_q[1], 12'hD46);
        end

        // Wrong parity bit.
        fr_q  = '{mk(8'h01, 1'b0, 1'b1, 1'b1)};
        gap_q = '{0};
        run_job("par");
        chk("par_perr_set", perr, 1);

        // One-cycle glitch, then a valid frame.
        fr_q   = '{mk(8'h3C, 1'b0, 1'b1, 1'b1)};
        gap_q  = '{1};
        glitch = 1;
        run_job("glitch");

        // Break: 14 bit times low.
        fr_q     = '{12'h000};
        gap_q    = '{0};
        tail_low = 2;
        run_job("break");
        chk("break_ferr_set", ferr, 1);

        // Abort during bit 5 of frame 2.
        wr_addr_q.delete();
        wr_din_q.delete();
        rend_cnt = 0;
        n_frames = AW'(3);
        @(negedge clk);
        ren = 1'b1;
        idle_bits(1);
        send_frame(mk(8'h5A, 1'b0, 1'b1, 1'b1));
        raw = mk(8'hC7, 1'b1, 1'b1, 1'b1);
        for (int b = 0; b < 5; b++) begin
            rxd = raw[b];
            repeat (C) @(negedge clk);
        end
        rxd = raw[5];
        @(negedge clk);
        ren = 1'b0;
        chk("abort_busy_before", busy, 1);
        @(negedge clk);
        chk("abort_busy_after", busy, 0);
        for (int b = 6; b < 12; b++) begin
            rxd = raw[b];
            repeat (C) @(negedge clk);
        end
        idle_bits(2);
        $display("job abort: writes=%0d rend=%0d", wr_din_q.size(), rend_cnt);
        chk("abort_nwr", wr_din_q.size(), 1);
        if (wr_din_q.size() >= 1) begin
            chk("abort_addr0", wr_addr_q[0], 0);
            chk("abort_din0", wr_din_q[0], mk(8'h5A, 1'b0, 1'b1, 1'b1));
        end
        chk("abort_rend", rend_cnt, 0);

        // Zero-frame job: rend the cycle after IDLE samples ren.
        wr_din_q.delete();
        wr_addr_q.delete();
        rend_cnt = 0;
        n_frames = '0;
        @(negedge clk);
        ren = 1'b1;
        @(negedge clk);
        chk("zero_rend_hi", rend, 1);
        @(negedge clk);
        chk("zero_rend_lo", rend, 0);
        chk("zero_busy", busy, 0);
        repeat (4) @(negedge clk);
        $display("job zero: writes=%0d rend=%0d", wr_din_q.size(), rend_cnt);
        chk("zero_nwr", wr_din_q.size(), 0);
        chk("zero_rend_cnt", rend_cnt, 1);
        ren = 1'b0;
        repeat (3) @(negedge clk);

        // Randomised jobs including parity and framing errors.
        for (int j = 0; j < 6; j++) begin
            build_rand($urandom_range(1, 4), 1'b1);
            run_job($sformatf("rnd%0d", j));
        end

        // Longest job: address climbs to the top, next job restarts at 0.
        build_rand(127, 1'b0);
        run_job("full");
        chk("full_addr_end", addr0, 127);
        build_rand(1, 1'b0);
        run_job("after_full");

        // Reset in the middle of a frame: no write, outputs back to reset values.
        wr_din_q.delete();
        wr_addr_q.delete();
        n_frames = AW'(1);
        @(negedge clk);
        ren = 1'b1;
        idle_bits(1);
        raw = mk(8'h96, 1'b0, 1'b1, 1'b1);
        for (int b = 0; b < 6; b++) begin
            rxd = raw[b];
            repeat (C) @(negedge clk);
        end
        rst = 1'b1;
        ren = 1'b0;
        rxd = 1'b1;
        @(negedge clk);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_csb0", csb0, 1);
        chk("rstmid_din0", din0, 0);
        rst = 1'b0;
        idle_bits(14);
        $display("job rstmid: writes=%0d", wr_din_q.size());
        chk("rstmid_nwr", wr_din_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
